// File: rtl/iq_discriminator.sv
// iq_discriminator: differential I/Q (cross-product) FM discriminator
// with per-chip integrate-and-dump hard decision.
module iq_discriminator #(
  parameter int DELAY = 4,
  parameter int SPC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  i_in,
  input  logic [4:0]  q_in,
  input  logic        chip_sync,
  output logic [10:0] disc_out,
  output logic        disc_valid,
  output logic        chip_out,
  output logic        chip_valid,
  output logic        locked
);
  typedef enum logic {FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] fill_q, fill_d;
  logic [4:0] i_dl_q [DELAY];
  logic [4:0] i_dl_d [DELAY];
  logic [4:0] q_dl_q [DELAY];
  logic [4:0] q_dl_d [DELAY];
  logic signed [9:0] i_del, q_del, i_new, q_new;
  logic signed [9:0] p1_q, p1_d, p2_q, p2_d;
  logic v1_q, v1_d;
  logic [10:0] disc_q, disc_d;
  logic dv_q, dv_d;
  logic [13:0] acc_q, acc_d, sum;
  logic [3:0] cnt_q, cnt_d;
  logic chip_q, chip_d, cv_q, cv_d;
  always_comb begin
    i_del = {{5{i_dl_q[DELAY-1][4]}}, i_dl_q[DELAY-1]};
    q_del = {{5{q_dl_q[DELAY-1][4]}}, q_dl_q[DELAY-1]};
    i_new = {{5{i_in[4]}}, i_in};
    q_new = {{5{q_in[4]}}, q_in};
    sum = acc_q + {{3{disc_q[10]}}, disc_q};
    state_d = state_q;
    fill_d = fill_q;
    i_dl_d = i_dl_q;
    q_dl_d = q_dl_q;
    p1_d = p1_q;
    p2_d = p2_q;
    v1_d = 1'b0;
    disc_d = v1_q ? {p1_q[9], p1_q} - {p2_q[9], p2_q} : disc_q;
    dv_d = v1_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    chip_d = chip_q;
    cv_d = 1'b0;
    if (in_valid) begin
      for (int k = DELAY - 1; k > 0; k--) begin
        i_dl_d[k] = i_dl_q[k-1];
        q_dl_d[k] = q_dl_q[k-1];
      end
      i_dl_d[0] = i_in;
      q_dl_d[0] = q_in;
      if (state_q == FILL) begin
        fill_d = fill_q + 4'd1;
        state_d = (fill_q == 4'(DELAY - 1)) ? RUN : FILL;
      end else begin
        p1_d = i_del * q_new;
        p2_d = q_del * i_new;
        v1_d = 1'b1;
      end
    end
    // chip_sync wins over a coincident sample or dump
    if (state_q == RUN) begin
      if (chip_sync) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (dv_q) begin
        if (cnt_q == 4'(SPC - 1)) begin
          chip_d = ~sum[13];
          cv_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q <= '0;
      i_dl_q <= '{default: '0};
      q_dl_q <= '{default: '0};
      p1_q <= '0;
      p2_q <= '0;
      v1_q <= 1'b0;
      disc_q <= '0;
      dv_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      chip_q <= 1'b0;
      cv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      i_dl_q <= i_dl_d;
      q_dl_q <= q_dl_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      v1_q <= v1_d;
      disc_q <= disc_d;
      dv_q <= dv_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      chip_q <= chip_d;
      cv_q <= cv_d;
    end
  end
  assign disc_out = disc_q;
  assign disc_valid = dv_q;
  assign chip_out = chip_q;
  assign chip_valid = cv_q;
  assign locked = (state_q == RUN);
endmodule

// File: doc/iq_discriminator.md
IQ_DISCRIMINATOR -- requirements
Module: iq_discriminator

Interface
REQ-001 SHALL have parameter DELAY, default 4, differential delay in input samples (legal 1..8).
REQ-002 SHALL have parameter SPC, default 4, discriminator samples per chip (legal 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe; i_in/q_in valid this cycle.
REQ-006 SHALL have port i_in  input  5  signed filtered I sample.
REQ-007 SHALL have port q_in  input  5  signed filtered Q sample.
REQ-008 SHALL have port chip_sync  input  1  one-cycle pulse restarting chip integration.
REQ-009 SHALL have port disc_out  output  11  signed discriminator value.
REQ-010 SHALL have port disc_valid  output  1  one-cycle strobe qualifying disc_out.
REQ-011 SHALL have port chip_out  output  1  hard chip decision.
REQ-012 SHALL have port chip_valid  output  1  one-cycle strobe qualifying chip_out.
REQ-013 SHALL have port locked  output  1  high once delay line is full (state RUN).

Function
REQ-014 SHALL keep a DELAY-deep I/Q delay line that shifts only on in_valid; non-valid cycles hold contents.
REQ-015 SHALL compute d = I_del*Q_new - Q_del*I_new, where I_del/Q_del is the sample DELAY valid samples older than the current one.
REQ-016 SHALL use full-precision signed arithmetic: 10-bit products, 11-bit difference, no truncation or saturation (range -496..+496).
REQ-017 SHALL pipeline in two stages: stage 1 registers both products on in_valid; stage 2 registers the difference into disc_out.
REQ-018 SHALL assert disc_valid exactly 2 cycles after the qualifying in_valid cycle, for one cycle; disc_out holds value until next disc_valid.
REQ-019 SHALL accept back-to-back in_valid (every cycle) with one disc_valid per accepted sample in RUN.
REQ-020 SHALL implement FSM FILL -> RUN: FILL counts valid samples; transition to RUN when count reaches DELAY; RUN exits only on reset.
REQ-021 SHALL not assert disc_valid for samples accepted in FILL; first disc_valid corresponds to sample index DELAY (0-based).
REQ-022 SHALL drive locked = 1 in RUN, 0 in FILL.
REQ-023 SHALL integrate disc_out into a 14-bit signed accumulator on each disc_valid, counting samples modulo SPC.
REQ-024 SHALL, on the SPC-th accumulated sample, output chip_out = 1 if sum incl. that sample >= 0 else 0, pulse chip_valid one cycle later than that disc_valid, and clear accumulator and count.
REQ-025 SHALL, on chip_sync, clear accumulator and sample count with no chip_valid; chip_sync coincident with disc_valid discards that sample, and overrides a coincident dump (no chip_valid).
REQ-026 SHALL ignore chip_sync in FILL (count and accumulator remain 0).
REQ-027 SHALL keep chip_out stable between chip_valid pulses.

Reset
REQ-028 SHALL, with reset high at a clock edge, clear delay line, pipeline, accumulator, counters; state FILL.
REQ-029 SHALL drive disc_out=0, disc_valid=0, chip_out=0, chip_valid=0, locked=0 during and after reset until new activity.
REQ-030 SHALL take reset priority over in_valid and chip_sync in the same cycle; in-flight pipeline samples are dropped.

Verification
REQ-031 Reset: assert reset 3 cycles with in_valid=1 -> all outputs 0, locked=0, no strobes.
REQ-032 Fill/latency (DELAY=4): I=5,Q=0 x4 then I=0,Q=5 -> locked after 4th sample; first disc_valid 2 cycles after 5th in_valid, disc_out=+25.
REQ-033 Reverse rotation: I=0,Q=5 x4 then I=5,Q=0 -> disc_out=-25; constant I=7,Q=0 stream -> disc_out=0.
REQ-034 Extremes: I_del=-16,Q_del=15, I_new=-16,Q_new=-16 -> disc_out=+496, no wrap.
REQ-035 Integrate/dump (SPC=4): disc 25,25,-25,-60 -> sum -35, chip_out=0, one chip_valid; next 4 of +10 -> chip_out=1.
REQ-036 Boundaries: chip_sync coincident with 4th disc_valid -> no chip_valid, count restarts; reset mid-stream -> FILL re-entered, DELAY new samples before next disc_valid.
